pipe_control_unit: RTL and testbench



---
 rtl/riscv_ctrl_pkg.sv | 51 +++++
 rtl/pipe_control_unit_if.sv | 46 ++++
 rtl/ctrl_decoder.sv | 100 ++++++++++
 rtl/pipe_control_unit.sv | 110 +++++++++++
 tb/tb_pipe_control_unit.sv | 398 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg -- shared definitions for the RV32I control decoders.
//   Opcode constants, the per-stage control bundle structs and the halt
//   FSM state enum used by the pipelined control unit and ctrl_decoder.
//   Optional feature macro: PIPE_CTRL_MULDIV_EN (see ctrl_decoder).
package riscv_ctrl_pkg;

  localparam logic [6:0] ARITHMETIC     = 7'b0110011;
  localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
  localparam logic [6:0] LOAD           = 7'b0000011;
  localparam logic [6:0] STORE          = 7'b0100011;
  localparam logic [6:0] BRANCH         = 7'b1100011;
  localparam logic [6:0] JAL            = 7'b1101111;
  localparam logic [6:0] JALR           = 7'b1100111;
  localparam logic [6:0] LUI            = 7'b0110111;
  localparam logic [6:0] AUIPC          = 7'b0010111;
  localparam logic [6:0] ECALL          = 7'b1110011;
  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

  typedef struct packed {
    logic alu_src;
    logic is_jal;
    logic is_jalr;
    logic branch;
    logic is_muldiv;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic write_enable;
    logic mem_to_reg;
    logic pc_to_reg;
  } wb_ctrl_t;

  // Full bundle as produced in ID and held in the ID/EX register.
  typedef struct packed {
    ex_ctrl_t  ex;
    mem_ctrl_t mem;
    wb_ctrl_t  wb;
  } ctrl_bundle_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

endpackage

// File: rtl/pipe_control_unit_if.sv
// pipe_control_unit_if -- ID-side inputs and per-stage control outputs of
//   the pipelined control unit.
//   master: drives id_valid/id_inst/id_rf17/stall/flush, observes controls.
//   slave : the control unit itself.
//   XLEN must match the XLEN of the pipe_control_unit it is bound to.
interface pipe_control_unit_if #(
  parameter int XLEN = 32
);
  logic            id_valid;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_rf17;
  logic            stall;
  logic            flush;

  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            id_illegal;

  logic            ex_alu_src;
  logic            ex_is_jal;
  logic            ex_is_jalr;
  logic            ex_branch;
  logic            ex_is_muldiv;
  logic            mem_read;
  logic            mem_write;
  logic            wb_write_enable;
  logic            wb_mem_to_reg;
  logic            wb_pc_to_reg;
  logic            halted;

  modport master (
    output id_valid, id_inst, id_rf17, stall, flush,
    input  id_uses_rs1, id_uses_rs2, id_illegal,
    input  ex_alu_src, ex_is_jal, ex_is_jalr, ex_branch, ex_is_muldiv,
    input  mem_read, mem_write,
    input  wb_write_enable, wb_mem_to_reg, wb_pc_to_reg, halted
  );

  modport slave (
    input  id_valid, id_inst, id_rf17, stall, flush,
    output id_uses_rs1, id_uses_rs2, id_illegal,
    output ex_alu_src, ex_is_jal, ex_is_jalr, ex_branch, ex_is_muldiv,
    output mem_read, mem_write,
    output wb_write_enable, wb_mem_to_reg, wb_pc_to_reg, halted
  );
endinterface

// File: rtl/ctrl_decoder.sv
// ctrl_decoder -- purely combinational RV32I control decoder.
//   inst_i     : instruction word
//   ctrl_o     : EX/MEM/WB control bundle (all-zero for ECALL and illegal)
//   uses_rs1_o : instruction reads rs1
//   uses_rs2_o : instruction reads rs2
//   is_ecall_o : SYSTEM opcode (ECALL)
//   illegal_o  : opcode/encoding not supported (not gated by any valid)
//   Macro PIPE_CTRL_MULDIV_EN: R-type with funct7=0000001 decodes as a
//   mul/div op; without it that encoding is illegal.
module ctrl_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [31:0]  inst_i,
  output ctrl_bundle_t ctrl_o,
  output logic         uses_rs1_o,
  output logic         uses_rs2_o,
  output logic         is_ecall_o,
  output logic         illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       unused_inst_bits;

  assign opcode = inst_i[6:0];
  assign funct7 = inst_i[31:25];
  // Register/immediate fields are consumed by the datapath, not here.
  assign unused_inst_bits = ^inst_i[24:7];

  always_comb begin
    ctrl_o     = '0;
    uses_rs1_o = 1'b0;
    uses_rs2_o = 1'b0;
    is_ecall_o = 1'b0;
    illegal_o  = 1'b0;
    case (opcode)
      ARITHMETIC: begin
        uses_rs1_o = 1'b1;
        uses_rs2_o = 1'b1;
        if (funct7 == FUNCT7_MULDIV) begin
`ifdef PIPE_CTRL_MULDIV_EN
          ctrl_o.wb.write_enable = 1'b1;
          ctrl_o.ex.is_muldiv    = 1'b1;
`else
          illegal_o = 1'b1;
`endif
        end else begin
          ctrl_o.wb.write_enable = 1'b1;
        end
      end
      ARITHMETIC_IMM: begin
        uses_rs1_o             = 1'b1;
        ctrl_o.wb.write_enable = 1'b1;
        ctrl_o.ex.alu_src      = 1'b1;
      end
      LOAD: begin
        uses_rs1_o             = 1'b1;
        ctrl_o.ex.alu_src      = 1'b1;
        ctrl_o.wb.write_enable = 1'b1;
        ctrl_o.mem.mem_read    = 1'b1;
        ctrl_o.wb.mem_to_reg   = 1'b1;
      end
      STORE: begin
        uses_rs1_o           = 1'b1;
        uses_rs2_o           = 1'b1;
        ctrl_o.ex.alu_src    = 1'b1;
        ctrl_o.mem.mem_write = 1'b1;
      end
      BRANCH: begin
        uses_rs1_o       = 1'b1;
        uses_rs2_o       = 1'b1;
        ctrl_o.ex.branch = 1'b1;
      end
      JAL: begin
        ctrl_o.ex.is_jal       = 1'b1;
        ctrl_o.ex.alu_src      = 1'b1;
        ctrl_o.wb.write_enable = 1'b1;
        ctrl_o.wb.pc_to_reg    = 1'b1;
      end
      JALR: begin
        uses_rs1_o             = 1'b1;
        ctrl_o.ex.is_jalr      = 1'b1;
        ctrl_o.ex.alu_src      = 1'b1;
        ctrl_o.wb.write_enable = 1'b1;
        ctrl_o.wb.pc_to_reg    = 1'b1;
      end
      LUI, AUIPC: begin
        ctrl_o.wb.write_enable = 1'b1;
        ctrl_o.ex.alu_src      = 1'b1;
      end
      ECALL: begin
        is_ecall_o = 1'b1;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pipe_control_unit.sv
// pipe_control_unit -- pipelined RV32I control: decodes ID and carries the
//   control bundle through ID/EX, EX/MEM and MEM/WB, with stall bubbles,
//   flush and an ECALL halt sequence that drains the pipe before halting.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : pipe_control_unit_if.slave (ID inputs, per-stage controls)
//   Parameters: XLEN (width of id_rf17), HALT_CODE (x17 value for halt).
//   Macro PIPE_CTRL_MULDIV_EN enables mul/div decode (see ctrl_decoder).
module pipe_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int HALT_CODE = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  pipe_control_unit_if.slave  bus
);

  ctrl_bundle_t dec_ctrl;
  logic         dec_uses_rs1;
  logic         dec_uses_rs2;
  logic         dec_is_ecall;
  logic         dec_illegal;

  halt_state_e  state_q, state_d;
  ctrl_bundle_t id_ex_q, id_ex_d;
  mem_ctrl_t    ex_mem_mem_q;
  wb_ctrl_t     ex_mem_wb_q;
  wb_ctrl_t     mem_wb_q;
  // Halt marker rides alongside the bundle so DRAIN knows when the
  // halting ECALL has reached MEM/WB.
  logic         marker_ex_q, marker_ex_d;
  logic         marker_mem_q;
  logic         marker_wb_q;

  logic         id_accept;
  logic         halt_req;

  ctrl_decoder u_decoder (
    .inst_i     (bus.id_inst),
    .ctrl_o     (dec_ctrl),
    .uses_rs1_o (dec_uses_rs1),
    .uses_rs2_o (dec_uses_rs2),
    .is_ecall_o (dec_is_ecall),
    .illegal_o  (dec_illegal)
  );

  assign bus.id_uses_rs1 = dec_uses_rs1;
  assign bus.id_uses_rs2 = dec_uses_rs2;
  assign bus.id_illegal  = bus.id_valid & dec_illegal;

  // flush dominates stall; either way the ID instruction is not consumed.
  assign id_accept = bus.id_valid & ~bus.stall & ~bus.flush & (state_q == RUN);
  assign halt_req  = id_accept & dec_is_ecall & (bus.id_rf17 == XLEN'(HALT_CODE));

  assign id_ex_d     = (id_accept & ~dec_illegal) ? dec_ctrl : '0;
  assign marker_ex_d = halt_req;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_ex_q      <= '0;
      ex_mem_mem_q <= '0;
      ex_mem_wb_q  <= '0;
      mem_wb_q     <= '0;
      marker_ex_q  <= 1'b0;
      marker_mem_q <= 1'b0;
      marker_wb_q  <= 1'b0;
    end else begin
      id_ex_q      <= id_ex_d;
      ex_mem_mem_q <= id_ex_q.mem;
      ex_mem_wb_q  <= id_ex_q.wb;
      mem_wb_q     <= ex_mem_wb_q;
      marker_ex_q  <= marker_ex_d;
      marker_mem_q <= marker_ex_q;
      marker_wb_q  <= marker_mem_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (halt_req) state_d = DRAIN;
      DRAIN:   if (marker_wb_q) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign bus.ex_alu_src      = id_ex_q.ex.alu_src;
  assign bus.ex_is_jal       = id_ex_q.ex.is_jal;
  assign bus.ex_is_jalr      = id_ex_q.ex.is_jalr;
  assign bus.ex_branch       = id_ex_q.ex.branch;
  assign bus.ex_is_muldiv    = id_ex_q.ex.is_muldiv;
  assign bus.mem_read        = ex_mem_mem_q.mem_read;
  assign bus.mem_write       = ex_mem_mem_q.mem_write;
  assign bus.wb_write_enable = mem_wb_q.write_enable;
  assign bus.wb_mem_to_reg   = mem_wb_q.mem_to_reg;
  assign bus.wb_pc_to_reg    = mem_wb_q.pc_to_reg;
  assign bus.halted          = (state_q == HALTED);

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb_pipe_control_unit -- self-checking bench for pipe_control_unit.
//   Reference model: spec decode table plus a queue of bundles accepted per
//   edge (newest first) and the edge index at which a halt was accepted.
//   Honours PIPE_CTRL_MULDIV_EN the same way the design does.
module tb_pipe_control_unit;

  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_LD   = 7'h03;
  localparam logic [6:0] OP_ST   = 7'h23;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_AUI  = 7'h17;
  localparam logic [6:0] OP_SYS  = 7'h73;
  localparam logic [31:0] HALT_CODE = 32'd10;

  localparam logic [31:0] I_LOAD  = 32'h00012083;
  localparam logic [31:0] I_STORE = 32'h00112023;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_ECALL = 32'h00000073;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  typedef struct packed {
    logic alu_src, is_jal, is_jalr, branch, is_muldiv;
    logic mem_read, mem_write;
    logic we, m2r, pc2r;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  pipe_control_unit_if #(.XLEN(32)) bus ();

  pipe_control_unit #(.XLEN(32), .HALT_CODE(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [10:0] dut_vec;
  assign dut_vec = {bus.halted, bus.ex_alu_src, bus.ex_is_jal, bus.ex_is_jalr,
                    bus.ex_branch, bus.ex_is_muldiv, bus.mem_read, bus.mem_write,
                    bus.wb_write_enable, bus.wb_mem_to_reg, bus.wb_pc_to_reg};

  int checks   = 0;
  int failures = 0;

  exp_t hist[$];
  int   halt_edge = -1;
  int   edge_no   = 0;

  logic        cur_v, cur_st, cur_fl;
  logic [31:0] cur_inst, cur_rf17;

  // ---------------- reference model ----------------
  function automatic exp_t ref_ctrl(input logic [31:0] inst);
    exp_t c;
    c = '0;
    case (inst[6:0])
      OP_R:                 begin c.we = 1'b1; c.is_muldiv = (inst[31:25] == 7'b0000001); end
      OP_I, OP_LUI, OP_AUI: begin c.we = 1'b1; c.alu_src = 1'b1; end
      OP_LD:   begin c.alu_src = 1'b1; c.we = 1'b1; c.mem_read = 1'b1; c.m2r = 1'b1; end
      OP_ST:   begin c.alu_src = 1'b1; c.mem_write = 1'b1; end
      OP_BR:   c.branch = 1'b1;
      OP_JAL:  begin c.is_jal = 1'b1; c.alu_src = 1'b1; c.we = 1'b1; c.pc2r = 1'b1; end
      OP_JALR: begin c.is_jalr = 1'b1; c.alu_src = 1'b1; c.we = 1'b1; c.pc2r = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  function automatic logic ref_known(input logic [31:0] inst);
    return inst[6:0] inside {OP_R, OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR,
                             OP_LUI, OP_AUI, OP_SYS};
  endfunction

  function automatic logic ref_illegal(input logic [31:0] inst);
    logic muldiv_bad;
`ifdef PIPE_CTRL_MULDIV_EN
    muldiv_bad = 1'b0;
`else
    muldiv_bad = (inst[6:0] == OP_R) && (inst[31:25] == 7'b0000001);
`endif
    return !ref_known(inst) || muldiv_bad;
  endfunction

  function automatic logic ref_uses1(input logic [31:0] inst);
    return !(inst[6:0] inside {OP_JAL, OP_LUI, OP_AUI, OP_SYS});
  endfunction

  function automatic logic ref_uses2(input logic [31:0] inst);
    return inst[6:0] inside {OP_R, OP_ST, OP_BR};
  endfunction

  function automatic logic [10:0] model_vec();
    logic h;
    exp_t e0, e1, e2;
    h  = (halt_edge >= 0) && (edge_no >= halt_edge + 4);
    e0 = hist[0];
    e1 = hist[1];
    e2 = hist[2];
    return {h, e0[9:5], e1[4:3], e2[2:0]};
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    halt_edge = -1;
    edge_no   = 0;
  endtask

  // ---------------- stimulus plumbing ----------------
  task automatic set_in(input logic v, input logic [31:0] inst, input logic [31:0] rf17,
                        input logic st, input logic fl);
    cur_v = v; cur_inst = inst; cur_rf17 = rf17; cur_st = st; cur_fl = fl;
    bus.id_valid = v;
    bus.id_inst  = inst;
    bus.id_rf17  = rf17;
    bus.stall    = st;
    bus.flush    = fl;
  endtask

  task automatic clock_edge();
    exp_t enter;
    logic take;
    take  = cur_v && !cur_st && !cur_fl && (halt_edge < 0);
    enter = '0;
    if (take && !ref_illegal(cur_inst)) enter = ref_ctrl(cur_inst);
    if (take && cur_inst[6:0] == OP_SYS && cur_rf17 == HALT_CODE) halt_edge = edge_no;
    @(posedge clk);
    #1;
    edge_no++;
    hist.push_front(enter);
    void'(hist.pop_back());
  endtask

  task automatic apply_reset();
    set_in(1'b1, I_LOAD, 32'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    set_in(1'b1, I_LOAD, 32'd0, 1'b0, 1'b0);
    model_reset();
    #3;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL reset_hold got=%b exp=%b", dut_vec, model_vec());
    end
    checks++;
    apply_reset();
    #1;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL reset_release got=%b exp=%b", dut_vec, model_vec());
    end
    checks++;
  endtask

  task automatic test_load();
    apply_reset();
    set_in(1'b1, I_LOAD, 32'd0, 1'b0, 1'b0);
    clock_edge();
    if (bus.ex_alu_src !== 1'b1) begin
      failures++; $display("FAIL load_ex_alu_src got=%b exp=1", bus.ex_alu_src);
    end
    checks++;
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL load_pipe edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
      clock_edge();
      if (i == 0 && bus.mem_read !== 1'b1) begin
        failures++; $display("FAIL load_mem_read got=%b exp=1", bus.mem_read);
      end
      if (i == 1 && {bus.wb_write_enable, bus.wb_mem_to_reg} !== 2'b11) begin
        failures++; $display("FAIL load_wb got=%b%b exp=11", bus.wb_write_enable, bus.wb_mem_to_reg);
      end
      if (i < 2) checks++;
    end
  endtask

  task automatic test_store_stall();
    int writes;
    writes = 0;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 2)       set_in(1'b1, I_STORE, 32'd0, 1'b1, 1'b0);
      else if (i == 2) set_in(1'b1, I_STORE, 32'd0, 1'b0, 1'b0);
      else             set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      clock_edge();
      if (bus.mem_write === 1'b1) writes++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL store_stall edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
    if (writes !== 1) begin
      failures++; $display("FAIL store_mem_write_count got=%0d exp=1", writes);
    end
    checks++;
  endtask

  task automatic test_jal_flush();
    int pc_hits;
    pc_hits = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) set_in(1'b1, I_JAL, 32'd0, 1'b1, 1'b1);
      else        set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      clock_edge();
      if (bus.wb_pc_to_reg === 1'b1) pc_hits++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL jal_flush edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
    if (pc_hits !== 0) begin
      failures++; $display("FAIL jal_pc_to_reg_count got=%0d exp=0", pc_hits);
    end
    checks++;
  endtask

  task automatic test_ecall_halt();
    int we_hits;
    we_hits = 0;
    apply_reset();
    set_in(1'b1, I_ECALL, 32'd10, 1'b0, 1'b0);
    clock_edge();
    set_in(1'b1, I_ADD, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      clock_edge();
      if (bus.wb_write_enable === 1'b1) we_hits++;
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ecall_halt edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
    if (bus.halted !== 1'b1 || we_hits !== 0) begin
      failures++; $display("FAIL ecall_halt_final halted=%b we_hits=%0d exp halted=1 we_hits=0",
                           bus.halted, we_hits);
    end
    checks++;
  endtask

  task automatic test_ecall_nohalt();
    apply_reset();
    // Stalled with a halt code, then released with a non-halt code.
    set_in(1'b1, I_ECALL, 32'd10, 1'b1, 1'b0);
    clock_edge();
    set_in(1'b1, I_ECALL, 32'd5, 1'b0, 1'b0);
    clock_edge();
    set_in(1'b1, I_ADD, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      clock_edge();
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL ecall_nohalt edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
    if (bus.halted !== 1'b0 || bus.wb_write_enable !== 1'b1) begin
      failures++; $display("FAIL ecall_nohalt_final halted=%b we=%b exp halted=0 we=1",
                           bus.halted, bus.wb_write_enable);
    end
    checks++;
  endtask

  task automatic test_reset_in_drain();
    apply_reset();
    set_in(1'b1, I_LOAD, 32'd0, 1'b0, 1'b0);
    clock_edge();
    set_in(1'b1, I_ECALL, 32'd10, 1'b0, 1'b0);
    clock_edge();
    set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    clock_edge();
    reset_n = 1'b0;
    model_reset();
    #2;
    if (dut_vec !== model_vec()) begin
      failures++; $display("FAIL drain_reset got=%b exp=%b", dut_vec, model_vec());
    end
    checks++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    set_in(1'b1, I_ADD, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      clock_edge();
      if (i == 0) set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL drain_after edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
  endtask

  task automatic test_muldiv();
    apply_reset();
    set_in(1'b1, I_MUL, 32'd0, 1'b0, 1'b0);
    #1;
    if (bus.id_illegal !== ref_illegal(I_MUL)) begin
      failures++; $display("FAIL muldiv_illegal got=%b exp=%b", bus.id_illegal, ref_illegal(I_MUL));
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      clock_edge();
      if (i == 0) set_in(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL muldiv_pipe edge=%0d got=%b exp=%b", edge_no, dut_vec, model_vec());
      end
      checks++;
    end
  endtask

  task automatic test_random();
    logic [31:0] inst, rf17, tmp;
    logic [6:0]  op, f7;
    int          sel;
    logic        v, st, fl;
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      if (halt_edge >= 0 && edge_no > halt_edge + 6) apply_reset();
      sel = $urandom_range(0, 13);
      case (sel)
        0, 12:   op = OP_R;
        1:       op = OP_I;
        2:       op = OP_LD;
        3:       op = OP_ST;
        4:       op = OP_BR;
        5:       op = OP_JAL;
        6:       op = OP_JALR;
        7:       op = OP_LUI;
        8:       op = OP_AUI;
        9:       op = OP_SYS;
        10:      op = 7'h7F;
        default: op = 7'h0F;
      endcase
      f7   = (sel == 12) ? 7'b0000001 : (($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00);
      tmp  = $urandom();
      inst = {f7, tmp[24:7], op};
      rf17 = ($urandom_range(0, 3) == 0) ? HALT_CODE : 32'($urandom_range(0, 20));
      v    = ($urandom_range(0, 9) != 0);
      st   = ($urandom_range(0, 4) == 0);
      fl   = ($urandom_range(0, 9) == 0);
      set_in(v, inst, rf17, st, fl);
      #1;
      if (bus.id_illegal !== (v && ref_illegal(inst))) begin
        failures++; $display("FAIL rand_illegal inst=%h got=%b exp=%b", inst, bus.id_illegal,
                             v && ref_illegal(inst));
      end
      checks++;
      if (ref_known(inst)) begin
        if ({bus.id_uses_rs1, bus.id_uses_rs2} !== {ref_uses1(inst), ref_uses2(inst)}) begin
          failures++; $display("FAIL rand_uses inst=%h got=%b%b exp=%b%b", inst, bus.id_uses_rs1,
                               bus.id_uses_rs2, ref_uses1(inst), ref_uses2(inst));
        end
        checks++;
      end
      clock_edge();
      if (dut_vec !== model_vec()) begin
        failures++; $display("FAIL rand_pipe n=%0d inst=%h got=%b exp=%b", n, inst, dut_vec, model_vec());
      end
      checks++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load();
    test_store_stall();
    test_jal_flush();
    test_ecall_halt();
    test_ecall_nohalt();
    test_reset_in_drain();
    test_muldiv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
